bcd_disp_mux: RTL
=================

Name: bcd_disp_mux

Overview:
- Time-multiplexed 6-digit seven-segment driver; consumes the two 3-digit packed-BCD words from the binary-to-BCD stage (DT, DL).
- Digits 0-2 show DL, digits 3-5 show DT, with leading-zero blanking and a dash for invalid nibbles.
- Inputs are snapshotted once per scan frame so no display tearing occurs.
- Sits between the BCD converter and the board's anode/cathode pins.

Parameters:
- CLK_DIV, 50000, clk cycles per digit slot; minimum 2. Prescaler width is clog2(CLK_DIV).
- NDIG, 6, number of digits scanned; fixed at 6, not overridable in practice.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- DT  input  12  packed BCD [11:8] hundreds, [7:4] tens, [3:0] ones (upper value)
- DL  input  12  packed BCD, same layout (lower value)
- en  input  1  display enable; 0 turns all anodes off
- an  output  6  anode selects, active-low, an[i] drives digit i
- seg  output  7  cathodes, active-low, seg[0]=a ... seg[6]=g
- dp  output  1  decimal point, active-low
- frame_tick  output  1  one-cycle pulse per completed frame

Behaviour:
- Reset, applied on a clk edge with rst=1:
  - Internal state: cnt=0, idx=0, snapDT=0, snapDL=0.
  - Outputs: an=6'b111111, seg=7'b1111111, dp=1, frame_tick=0.
  - rst mid-frame aborts the scan immediately, with no partial capture.
- Prescaler:
  - cnt increments every cycle.
  - At cnt==CLK_DIV-1, cnt wraps to 0 and idx advances; idx wraps 5->0.
  - Each digit is therefore held for exactly CLK_DIV cycles.
- Snapshot:
  - Taken in the cycle where cnt==CLK_DIV-1 and idx==5 (end of frame): snapDT<=DT, snapDL<=DL.
  - frame_tick=1 in the cycle after the capture edge, for exactly one cycle.
  - The first frame after reset displays the zero snapshot ("  0  0").
- Digit mapping, by idx:
  - 0: snapDL ones; 1: snapDL tens; 2: snapDL hundreds.
  - 3: snapDT ones; 4: snapDT tens; 5: snapDT hundreds.
- Blanking, applied per 3-digit group:
  - Hundreds is blanked if its nibble is 0.
  - Tens is blanked if both hundreds and tens are 0.
  - Ones is never blanked.
  - Blanked digit: seg=7'b1111111 (anode still pulsed).
- Invalid nibble (>9): seg=7'b0111111 (g only, a dash). An invalid nibble counts as non-zero for blanking.
- Segment patterns (active-low, g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- dp: 0 when idx==3 (separator between the two values), else 1.
- Output timing:
  - an, seg and dp are registered and lag the idx change by 1 cycle.
  - an is one-hot-low: an[idx]=0, all others 1.
- en:
  - en=0 forces an=6'b111111 on the next edge.
  - cnt, idx, snapshot and frame_tick keep running while en=0.
  - Re-enabling resumes on the current idx with no resync.
- Input changes between capture edges never affect the displayed values.

Decomposition:
- Shared include file holds:
  - the ten segment-pattern constants, SEG_BLANK and SEG_DASH;
  - the digit-to-nibble index constants.
- One natural combinational sub-module, bcd_to_seg7:
  - inputs: 4-bit nibble and a blank flag; output: 7-bit active-low segments.
  - It implements the segment table, the dash for >9, and blank.
- Prescaler, scan counter, snapshot, blanking logic and output registers stay in bcd_disp_mux.

Test Plan:
- Setup for all scenarios: CLK_DIV=4. Hold rst=1 for 3 cycles, then release.
- Reset values: an=111111, seg=1111111, dp=1 during reset. First frame shows digit0 and digit3 as "0" (seg=1000000) and the other digits blank. Each digit is held 4 cycles; frame_tick first pulses 24 cycles after reset release.
- DT=12'h123, DL=12'h255 applied in the first frame, before the first capture: second frame yields digits 0..5 = 5,5,2,3,2,1. dp=0 only while an=110111.
- Leading-zero blanking: DT=12'h009, DL=12'h040. Digit3=9, digits 4-5 blank; digit0=0, digit1=4, digit2 blank.
- Invalid nibble: DL=12'h1A0. Digit1 shows seg=0111111 and digit2 shows 1 (not blanked).
- No tearing and en gating:
  - DT changes mid-frame; display is unchanged until after the next frame_tick.
  - en=0 for 10 cycles gives an=111111 with frame_tick spacing still 24 cycles.
- rst pulsed mid-frame at idx=3: outputs return to reset values on the next edge, and the snapshot reads 0.

Source files
------------

// File: rtl/bcd_disp_mux_pkg.sv
// Shared constants for the 6-digit BCD display multiplexer.
// Holds the active-low segment patterns (bit order g..a) and the digit-slot
// enumeration that maps scan index to the BCD nibble being shown.
package bcd_disp_mux_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Scan slot -> nibble: slots 0-2 show the lower value, 3-5 the upper value.
    typedef enum logic [2:0] {
        DIG_DL_ONES = 3'd0,
        DIG_DL_TENS = 3'd1,
        DIG_DL_HUND = 3'd2,
        DIG_DT_ONES = 3'd3,
        DIG_DT_TENS = 3'd4,
        DIG_DT_HUND = 3'd5
    } dig_idx_e;

endpackage

// File: rtl/bcd_disp_mux_if.sv
// Display-side bundle for bcd_disp_mux.
//   DT, DL      : packed 3-digit BCD values (upper / lower)
//   en          : display enable
//   an          : anode selects, active-low, one-hot while enabled
//   seg, dp     : cathodes and decimal point, active-low
//   frame_tick  : one-cycle pulse per completed scan frame
// master = BCD source / board side, slave = the display multiplexer.
interface bcd_disp_mux_if;
    logic [11:0] DT;
    logic [11:0] DL;
    logic        en;
    logic [5:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;

    modport master (
        output DT, DL, en,
        input  an, seg, dp, frame_tick
    );

    modport slave (
        input  DT, DL, en,
        output an, seg, dp, frame_tick
    );
endinterface

// File: rtl/bcd_disp_mux_bcd_to_seg7.sv
// BCD nibble to active-low seven-segment decoder.
//   i_nibble : BCD digit; values above 9 render as a dash
//   i_blank  : force all segments off (leading-zero blanking)
//   o_seg    : active-low segments, bit 0 = a ... bit 6 = g
module bcd_to_seg7
    import bcd_disp_mux_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_blank,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_DASH;
        if (i_blank) begin
            o_seg = SEG_BLANK;
        end else begin
            case (i_nibble)
                4'd0:    o_seg = SEG_0;
                4'd1:    o_seg = SEG_1;
                4'd2:    o_seg = SEG_2;
                4'd3:    o_seg = SEG_3;
                4'd4:    o_seg = SEG_4;
                4'd5:    o_seg = SEG_5;
                4'd6:    o_seg = SEG_6;
                4'd7:    o_seg = SEG_7;
                4'd8:    o_seg = SEG_8;
                4'd9:    o_seg = SEG_9;
                default: o_seg = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/bcd_disp_mux.sv
// Time-multiplexed 6-digit seven-segment driver.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : bcd_disp_mux_if.slave (DT/DL/en in, an/seg/dp/frame_tick out)
// Each digit slot lasts CLK_DIV cycles. DT/DL are captured only at the end of
// a frame so a frame never mixes old and new values. an/seg/dp are registered
// and trail the scan index by one cycle.
module bcd_disp_mux
    import bcd_disp_mux_pkg::*;
#(
    parameter int CLK_DIV = 50000,
    parameter int NDIG    = 6
) (
    input  logic          clk,
    input  logic          rst,
    bcd_disp_mux_if.slave bus
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    logic [11:0]   r_snap_dt;
    logic [11:0]   r_snap_dl;
    logic [5:0]    r_an;
    logic [6:0]    r_seg;
    logic          r_dp;
    logic          r_frame_tick;

    logic          w_end_slot;
    logic          w_end_frame;
    logic [3:0]    w_nibble;
    logic          w_blank;
    logic [6:0]    w_seg;

    assign w_end_slot  = (r_cnt == CW'(CLK_DIV - 1));
    assign w_end_frame = w_end_slot && (r_idx == 3'(NDIG - 1));

    // Leading-zero blanking per 3-digit group; a dash nibble is non-zero,
    // so it keeps the digits below it lit.
    always_comb begin
        w_nibble = r_snap_dl[3:0];
        w_blank  = 1'b0;
        case (r_idx)
            DIG_DL_ONES: w_nibble = r_snap_dl[3:0];
            DIG_DL_TENS: begin
                w_nibble = r_snap_dl[7:4];
                w_blank  = (r_snap_dl[11:4] == 8'h00);
            end
            DIG_DL_HUND: begin
                w_nibble = r_snap_dl[11:8];
                w_blank  = (r_snap_dl[11:8] == 4'h0);
            end
            DIG_DT_ONES: w_nibble = r_snap_dt[3:0];
            DIG_DT_TENS: begin
                w_nibble = r_snap_dt[7:4];
                w_blank  = (r_snap_dt[11:4] == 8'h00);
            end
            DIG_DT_HUND: begin
                w_nibble = r_snap_dt[11:8];
                w_blank  = (r_snap_dt[11:8] == 4'h0);
            end
            default: w_blank = 1'b1;
        endcase
    end

    bcd_to_seg7 u_seg7 (
        .i_nibble (w_nibble),
        .i_blank  (w_blank),
        .o_seg    (w_seg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_snap_dt    <= '0;
            r_snap_dl    <= '0;
            r_an         <= 6'b111111;
            r_seg        <= SEG_BLANK;
            r_dp         <= 1'b1;
            r_frame_tick <= 1'b0;
        end else begin
            if (w_end_slot) begin
                r_cnt <= '0;
                r_idx <= (r_idx == 3'(NDIG - 1)) ? 3'd0 : r_idx + 3'd1;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end

            if (w_end_frame) begin
                r_snap_dt <= bus.DT;
                r_snap_dl <= bus.DL;
            end
            r_frame_tick <= w_end_frame;

            // Disabling only gates the anodes; the scan keeps its phase.
            r_an  <= bus.en ? ~(6'b000001 << r_idx) : 6'b111111;
            r_seg <= w_seg;
            r_dp  <= (r_idx != DIG_DT_ONES);
        end
    end

    assign bus.an         = r_an;
    assign bus.seg        = r_seg;
    assign bus.dp         = r_dp;
    assign bus.frame_tick = r_frame_tick;

endmodule
